deserializer_rx: RTL and testbench

Receive end of the MSB-first serial link driven by the team's message serializer. Samples one data bit per clock while the sender's data flag is high and assembles a MSG_SIZE-bit word. Its bit count output uses the same width and semantics as the serializer's counter input, so a completed word can feed a downstream serializer or cipher stage directly. Sits between the chip input pins and the message/key registers.

---
 rtl/deserializer_rx_pkg.sv | 20 ++
 rtl/deserializer_rx.sv | 103 ++++++++++
 tb/tb_deserializer_rx.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/deserializer_rx_pkg.sv
// Shared definitions for the serial receive path: FSM state encoding and
// the bit-counter width used by both the serializer and the deserializer.
package deserializer_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2,
        ERR   = 2'd3
    } rx_state_t;

    localparam int MSG_SIZE_DEF = 64;
    localparam int CNT_W        = $clog2(MSG_SIZE_DEF) + 1;

    // Counter must be able to hold the value MSG_SIZE itself, hence the +1.
    function automatic int cnt_width(input int msg_size);
        return $clog2(msg_size) + 1;
    endfunction

endpackage

// File: rtl/deserializer_rx.sv
// MSB-first serial word receiver: shifts one bit per enabled clock while the
// sender's flag is high, reports completion, short frames and overruns.
module deserializer_rx
    import deserializer_rx_pkg::*;
#(
    parameter int MSG_SIZE = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ena,
    input  logic                             iData_in,
    input  logic                             iData_flag,
    input  logic                             iClear,
    output logic [MSG_SIZE-1:0]              oData_out,
    output logic [cnt_width(MSG_SIZE)-1:0]   oCounter,
    output logic                             oDone,
    output logic                             oShort_err,
    output logic                             oOverrun
);

    localparam int CW = cnt_width(MSG_SIZE);

    rx_state_t         state_q, state_d;
    logic [MSG_SIZE-1:0] data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              short_q, short_d;
    logic              ovr_q, ovr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            short_q <= short_d;
            ovr_q   <= ovr_d;
        end
    end

    // iClear outranks the enable so a stalled consumer can still recycle the block.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        short_d = short_q;
        ovr_d   = ovr_q;

        if (iClear) begin
            state_d = IDLE;
            data_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            short_d = 1'b0;
            ovr_d   = 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (iData_flag) begin
                        data_d  = {data_q[MSG_SIZE-2:0], iData_in};
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (iData_flag) begin
                        data_d = {data_q[MSG_SIZE-2:0], iData_in};
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == CW'(MSG_SIZE)) begin
                            state_d = FULL;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = ERR;
                        short_d = 1'b1;
                    end
                end
                FULL: begin
                    if (iData_flag) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oData_out  = data_q;
    assign oCounter   = cnt_q;
    assign oDone      = done_q;
    assign oShort_err = short_q;
    assign oOverrun   = ovr_q;

endmodule

// File: tb/tb_deserializer_rx.sv
// Self-checking bench for deserializer_rx: directed scenarios plus randomized
// frames checked against a frame-level model of the expected result.
module tb_deserializer_rx;

    logic clk = 1'b0;
    logic rst_n, ena, iClear;
    logic d8, f8, d64, f64;

    logic [7:0]  out8;
    logic [3:0]  cnt8;
    logic        done8, short8, ovr8;
    logic [63:0] out64;
    logic [6:0]  cnt64;
    logic        done64, short64, ovr64;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    deserializer_rx #(.MSG_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .iData_in(d8), .iData_flag(f8), .iClear(iClear),
        .oData_out(out8), .oCounter(cnt8), .oDone(done8),
        .oShort_err(short8), .oOverrun(ovr8)
    );

    deserializer_rx #(.MSG_SIZE(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .iData_in(d64), .iData_flag(f64), .iClear(iClear),
        .oData_out(out64), .oCounter(cnt64), .oDone(done64),
        .oShort_err(short64), .oOverrun(ovr64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic b, input logic f);
        d8 = b;
        f8 = f;
        step();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send8(v[i], 1'b1);
    endtask

    task automatic clear_pulse();
        iClear = 1'b1;
        d8 = 1'b0;
        f8 = 1'b0;
        step();
        iClear = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] act8;
        logic [73:0] act64;
        rst_n = 1'b0;
        d8 = 1'b1; f8 = 1'b1;
        step();
        step();
        compared++;
        act8 = {out8, cnt8, done8, short8, ovr8};
        if (act8 !== 17'h0) begin
            mismatched++;
            $display("[TB] FAIL reset8: got %h expected %h", act8, 17'h0);
        end
        compared++;
        act64 = {out64, cnt64, done64, short64, ovr64};
        if (act64 !== 74'h0) begin
            mismatched++;
            $display("[TB] FAIL reset64: got %h expected %h", act64, 74'h0);
        end
        rst_n = 1'b1;
        d8 = 1'b0; f8 = 1'b0;
        step();
    endtask

    task automatic test_basic_a5();
        logic [16:0] act;
        send_byte(8'hA5);
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== {8'hA5, 4'd8, 3'b100}) begin
            mismatched++;
            $display("[TB] FAIL a5_done: got %h expected %h", act, {8'hA5, 4'd8, 3'b100});
        end
        send8(1'b0, 1'b0);
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== {8'hA5, 4'd8, 3'b100}) begin
            mismatched++;
            $display("[TB] FAIL a5_trailer: got %h expected %h", act, {8'hA5, 4'd8, 3'b100});
        end
    endtask

    task automatic test_loopback64();
        logic [63:0] sr;
        logic [73:0] act, expv;
        sr = 64'h0123_4567_89AB_CDEF;
        expv = {64'h0123_4567_89AB_CDEF, 7'd64, 3'b100};
        for (int i = 0; i < 64; i++) begin
            d64 = sr[63];
            f64 = 1'b1;
            sr  = {sr[62:0], 1'b0};
            step();
        end
        compared++;
        act = {out64, cnt64, done64, short64, ovr64};
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL loop64_done: got %h expected %h", act, expv);
        end
        d64 = 1'b0; f64 = 1'b0;
        step();
        compared++;
        act = {out64, cnt64, done64, short64, ovr64};
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL loop64_trailer: got %h expected %h", act, expv);
        end
    endtask

    task automatic test_short_frame();
        logic [16:0] act;
        clear_pulse();
        send8(1'b1, 1'b1); send8(1'b0, 1'b1); send8(1'b1, 1'b1);
        send8(1'b1, 1'b1); send8(1'b0, 1'b1);
        send8(1'b0, 1'b0);
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== {8'h16, 4'd5, 3'b010}) begin
            mismatched++;
            $display("[TB] FAIL short_err: got %h expected %h", act, {8'h16, 4'd5, 3'b010});
        end
        send8(1'b1, 1'b1); send8(1'b1, 1'b1);
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== {8'h16, 4'd5, 3'b010}) begin
            mismatched++;
            $display("[TB] FAIL short_frozen: got %h expected %h", act, {8'h16, 4'd5, 3'b010});
        end
        clear_pulse();
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== 17'h0) begin
            mismatched++;
            $display("[TB] FAIL short_clear: got %h expected %h", act, 17'h0);
        end
        send_byte(8'h3C);
        send8(1'b0, 1'b0);
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== {8'h3C, 4'd8, 3'b100}) begin
            mismatched++;
            $display("[TB] FAIL after_clear_3c: got %h expected %h", act, {8'h3C, 4'd8, 3'b100});
        end
    endtask

    task automatic test_overrun();
        logic [16:0] act;
        clear_pulse();
        send_byte(8'hFF);
        send8(1'b0, 1'b1);
        send8(1'b1, 1'b1);
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== {8'hFF, 4'd8, 3'b101}) begin
            mismatched++;
            $display("[TB] FAIL overrun: got %h expected %h", act, {8'hFF, 4'd8, 3'b101});
        end
    endtask

    task automatic test_stall();
        logic [16:0] act;
        clear_pulse();
        send8(1'b0, 1'b1); send8(1'b1, 1'b1); send8(1'b0, 1'b1); send8(1'b1, 1'b1);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send8(i[0], ~i[0]);
            compared++;
            act = {out8, cnt8, done8, short8, ovr8};
            if (act !== {8'h05, 4'd4, 3'b000}) begin
                mismatched++;
                $display("[TB] FAIL stall_hold: got %h expected %h", act, {8'h05, 4'd4, 3'b000});
            end
        end
        ena = 1'b1;
        send8(1'b1, 1'b1); send8(1'b0, 1'b1); send8(1'b1, 1'b1); send8(1'b0, 1'b1);
        send8(1'b0, 1'b0);
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== {8'h5A, 4'd8, 3'b100}) begin
            mismatched++;
            $display("[TB] FAIL stall_word: got %h expected %h", act, {8'h5A, 4'd8, 3'b100});
        end
    endtask

    task automatic test_reset_midframe_and_clear_drop();
        logic [16:0] act;
        clear_pulse();
        for (int i = 0; i < 6; i++) send8(1'b1, 1'b1);
        rst_n = 1'b0;
        send8(1'b1, 1'b1);
        rst_n = 1'b1;
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== 17'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_midframe: got %h expected %h", act, 17'h0);
        end
        iClear = 1'b1;
        send8(1'b1, 1'b1);
        iClear = 1'b0;
        compared++;
        act = {out8, cnt8, done8, short8, ovr8};
        if (act !== 17'h0) begin
            mismatched++;
            $display("[TB] FAIL clear_drops_bit: got %h expected %h", act, 17'h0);
        end
        send8(1'b0, 1'b0);
    endtask

    // Frame-level model: only the first 8 flagged bits count, a frame shorter
    // than 8 ends in a short error, and any flagged bit past 8 is an overrun.
    task automatic test_random();
        logic        bits[$];
        logic        b;
        logic [7:0]  wexp;
        logic [16:0] act, expv;
        int n, got, k;
        for (int iter = 0; iter < 40; iter++) begin
            clear_pulse();
            bits.delete();
            n   = $urandom_range(1, 11);
            got = 0;
            while (got < n) begin
                if ($urandom_range(0, 3) == 0) begin
                    ena = 1'b0;
                    send8(1'($urandom), 1'($urandom));
                    ena = 1'b1;
                    k = (got < 8) ? got : 8;
                    compared++;
                    if (cnt8 !== 4'(k)) begin
                        mismatched++;
                        $display("[TB] FAIL rand_stall_cnt: got %0d expected %0d", cnt8, k);
                    end
                end else begin
                    b = 1'($urandom);
                    bits.push_back(b);
                    send8(b, 1'b1);
                    got++;
                end
            end
            send8(1'b0, 1'b0);
            k = (n < 8) ? n : 8;
            wexp = '0;
            for (int i = 0; i < k; i++) wexp = {wexp[6:0], bits[i]};
            expv = {wexp, 4'(k), (n >= 8), (n < 8), (n > 8)};
            compared++;
            act = {out8, cnt8, done8, short8, ovr8};
            if (act !== expv) begin
                mismatched++;
                $display("[TB] FAIL rand_frame n=%0d: got %h expected %h", n, act, expv);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        iClear = 1'b0;
        d8 = 1'b0; f8 = 1'b0;
        d64 = 1'b0; f64 = 1'b0;
        $display("[TB] starting deserializer_rx bench");
        test_reset();
        test_basic_a5();
        test_loopback64();
        test_short_frame();
        test_overrun();
        test_stall();
        test_reset_midframe_and_clear_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
